// File: rtl/fft_ring_pkg.sv
// Shared types for the FFT ring: message format, point width and the
// pair-buffer FSM state encoding.
package fft_ring_pkg;

  localparam int unsigned FFT_PT_W  = 16;
  localparam int unsigned NODE_ID_W = 8;

  // One message travelling on either ring direction
  typedef struct packed {
    logic [NODE_ID_W-1:0] src_node_id;
    logic [NODE_ID_W-1:0] dst_node_id;
    logic                 msg_type;
    logic [FFT_PT_W-1:0]  fft_pt;
  } ts_fft_ring_msg;

  // Pair-buffer control states
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDone    = 2'd2
  } fft_pair_state_e;

  // Compare a message source against a 32-bit partner ID
  function automatic logic id_match(input logic [NODE_ID_W-1:0] src,
                                    input logic [31:0]          nid);
    return src == nid[NODE_ID_W-1:0];
  endfunction

endpackage

// File: rtl/fft_ring_pt_fifo.sv
// Small synchronous FIFO holding FFT points for one ring direction.
// Push into a full FIFO is only legal together with a pop; the caller
// guarantees that, and pop is only issued when non-empty.
module fft_ring_pt_fifo #(
  parameter int unsigned DEPTH = 32'd2,
  parameter int unsigned WIDTH = 32'd16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer, occupancy and storage next-state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_i && pop_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fft_ring_pair_buf.sv
// Collects forward/reverse ring points from the per-stage partner node and
// presents them as operand pairs to the butterfly.
// Optional feature: define FFT_RING_PAIR_TYPE_CHK_EN to enforce msg_type per
// direction and report mismatches on type_err.
module fft_ring_pair_buf
  import fft_ring_pkg::*;
#(
  parameter int unsigned              NNNODES       = 32'd16,
  parameter int unsigned              NODEID        = 32'd0,
  parameter int unsigned              NSTAGES       = 32'd3,
  parameter logic [NSTAGES-1:0][31:0] NIDS          = '0,
  parameter int unsigned              PTS_PER_STAGE = 32'd4,
  parameter int unsigned              NPBUFFS       = 32'd2,
  parameter logic                     FWD_MSG_TYPE  = 1'b0,
  parameter logic                     REV_MSG_TYPE  = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  input  ts_fft_ring_msg      rx_msg_f,
  input  logic                rx_vld_f,
  input  ts_fft_ring_msg      rx_msg_r,
  input  logic                rx_vld_r,
  input  logic                start,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [FFT_PT_W-1:0] out_pt_f,
  output logic [FFT_PT_W-1:0] out_pt_r,
  output logic [1:0]          out_stage,
  output logic                stage_done,
  output logic                done,
  output logic                ovf_err,
  output logic                type_err
);

  localparam int unsigned CntW = (PTS_PER_STAGE > 1) ? $clog2(PTS_PER_STAGE) : 1;

  // out_stage is 2 bits wide, so at most four stages are representable
  if (NODEID >= NNNODES || NSTAGES == 0 || NSTAGES > 4 || PTS_PER_STAGE == 0 ||
      NPBUFFS == 0 || FWD_MSG_TYPE == REV_MSG_TYPE) begin : g_param_chk
    $error("fft_ring_pair_buf: illegal parameter combination");
  end

  fft_pair_state_e state_q, state_d;
  logic [1:0]      stage_q, stage_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stage_done_q, stage_done_d;
  logic            ovf_q, ovf_d;
  logic            type_err_q, type_err_d;

  logic [31:0]         nid_cur;
  logic                src_ok_f, src_ok_r;
  logic                type_ok_f, type_ok_r;
  logic                acc_f, acc_r;
  logic                push_f, push_r;
  logic                full_f, full_r, empty_f, empty_r;
  logic [FFT_PT_W-1:0] head_f, head_r;
  logic                hs, last_pair, last_stage;

  // Partner ID for the current stage
  always_comb begin
    nid_cur = '0;
    for (int i = 0; i < int'(NSTAGES); i++) begin
      if (stage_q == 2'(i)) nid_cur = NIDS[i];
    end
  end

  // Message acceptance and FIFO push decisions
  always_comb begin
    src_ok_f = (state_q == StCollect) && rx_vld_f && id_match(rx_msg_f.src_node_id, nid_cur);
    src_ok_r = (state_q == StCollect) && rx_vld_r && id_match(rx_msg_r.src_node_id, nid_cur);
`ifdef FFT_RING_PAIR_TYPE_CHK_EN
    type_ok_f = (rx_msg_f.msg_type == FWD_MSG_TYPE);
    type_ok_r = (rx_msg_r.msg_type == REV_MSG_TYPE);
`else
    type_ok_f = 1'b1;
    type_ok_r = 1'b1;
`endif
    acc_f  = src_ok_f && type_ok_f;
    acc_r  = src_ok_r && type_ok_r;
    // A full FIFO only takes a new point when its head leaves this cycle
    push_f = acc_f && (!full_f || hs);
    push_r = acc_r && (!full_r || hs);
  end

  assign hs         = out_vld && out_rdy;
  assign last_pair  = (cnt_q == CntW'(PTS_PER_STAGE - 1));
  assign last_stage = (stage_q == 2'(NSTAGES - 1));

  fft_ring_pt_fifo #(
    .DEPTH (NPBUFFS),
    .WIDTH (FFT_PT_W)
  ) u_fifo_f (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push_f),
    .pop_i   (hs),
    .wdata_i (rx_msg_f.fft_pt),
    .rdata_o (head_f),
    .full_o  (full_f),
    .empty_o (empty_f)
  );

  fft_ring_pt_fifo #(
    .DEPTH (NPBUFFS),
    .WIDTH (FFT_PT_W)
  ) u_fifo_r (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push_r),
    .pop_i   (hs),
    .wdata_i (rx_msg_r.fft_pt),
    .rdata_o (head_r),
    .full_o  (full_r),
    .empty_o (empty_r)
  );

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StCollect;
      StCollect: if (hs && last_pair && last_stage) state_d = StDone;
      StDone:    if (start) state_d = StCollect;
      default:   state_d = StIdle;
    endcase
  end

  // Stage / pair counters and sticky error flags
  always_comb begin
    stage_d      = stage_q;
    cnt_d        = cnt_q;
    stage_done_d = 1'b0;
    ovf_d        = ovf_q | (acc_f && full_f && !hs) | (acc_r && full_r && !hs);
`ifdef FFT_RING_PAIR_TYPE_CHK_EN
    type_err_d   = type_err_q | (src_ok_f && !type_ok_f) | (src_ok_r && !type_ok_r);
`else
    type_err_d   = 1'b0;
`endif
    if (state_q != StCollect) begin
      if (start) begin
        stage_d = '0;
        cnt_d   = '0;
      end
    end else if (hs) begin
      if (last_pair) begin
        cnt_d        = '0;
        stage_d      = stage_q + 1'b1;
        stage_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      stage_q      <= '0;
      cnt_q        <= '0;
      stage_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      type_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      cnt_q        <= cnt_d;
      stage_done_q <= stage_done_d;
      ovf_q        <= ovf_d;
      type_err_q   <= type_err_d;
    end
  end

  // Outputs; heads are masked when empty so idle outputs read as zero
  always_comb begin
    out_vld    = rstn && (state_q != StIdle) && !empty_f && !empty_r;
    out_pt_f   = empty_f ? '0 : head_f;
    out_pt_r   = empty_r ? '0 : head_r;
    out_stage  = stage_q;
    stage_done = stage_done_q;
    done       = (state_q == StDone);
    ovf_err    = ovf_q;
    type_err   = type_err_q;
  end

endmodule

// File: tb/tb_fft_ring_pair_buf.sv
// Self-checking bench for fft_ring_pair_buf: directed steps then random traffic,
// compared each cycle with a queue-based reference model.
module tb_fft_ring_pair_buf;
  import fft_ring_pkg::*;

  localparam int unsigned NST   = 3;
  localparam int unsigned PTS   = 4;
  localparam int unsigned DEPTH = 2;
  localparam logic [NST-1:0][31:0] NIDS_P = {32'd7, 32'd5, 32'd3};
`ifdef FFT_RING_PAIR_TYPE_CHK_EN
  localparam bit TypeChk = 1'b1;
`else
  localparam bit TypeChk = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn, start, out_rdy, rx_vld_f, rx_vld_r;
  ts_fft_ring_msg rx_msg_f, rx_msg_r;
  logic out_vld, stage_done, done, ovf_err, type_err;
  logic [FFT_PT_W-1:0] out_pt_f, out_pt_r;
  logic [1:0] out_stage;

  always #5 clk = ~clk;

  fft_ring_pair_buf #(
    .NNNODES       (16),
    .NODEID        (0),
    .NSTAGES       (NST),
    .NIDS          (NIDS_P),
    .PTS_PER_STAGE (PTS),
    .NPBUFFS       (DEPTH),
    .FWD_MSG_TYPE  (1'b0),
    .REV_MSG_TYPE  (1'b1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_msg_f   (rx_msg_f),
    .rx_vld_f   (rx_vld_f),
    .rx_msg_r   (rx_msg_r),
    .rx_vld_r   (rx_vld_r),
    .start      (start),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_pt_f   (out_pt_f),
    .out_pt_r   (out_pt_r),
    .out_stage  (out_stage),
    .stage_done (stage_done),
    .done       (done),
    .ovf_err    (ovf_err),
    .type_err   (type_err)
  );

  int checks = 0;
  int failures = 0;
  int sd_seen = 0;
  int nid_tab[3] = '{3, 5, 7};

  // Reference model: 0 idle, 1 collecting, 2 finished
  int m_state, m_stage, m_cnt;
  bit m_sd, m_ovf, m_terr;
  int qf[$];
  int qr[$];

  function automatic ts_fft_ring_msg mk(input int src, input int typ, input int pt);
    ts_fft_ring_msg m;
    m.src_node_id = NODE_ID_W'(src);
    m.dst_node_id = '0;
    m.msg_type    = typ[0];
    m.fft_pt      = FFT_PT_W'(pt);
    return m;
  endfunction

  function automatic int nid_of(input int s);
    return (s < int'(NST)) ? nid_tab[s] : -1;
  endfunction

  function automatic bit exp_vld();
    return rstn && (m_state != 0) && (qf.size() > 0) && (qr.size() > 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    bit hs, mf, mr, tf, tr;
    if (!rstn) begin
      m_state = 0; m_stage = 0; m_cnt = 0;
      m_sd = 0; m_ovf = 0; m_terr = 0;
      qf.delete(); qr.delete();
      return;
    end
    hs = exp_vld() && out_rdy;
    m_sd = 0;
    mf = (m_state == 1) && rx_vld_f && (int'(rx_msg_f.src_node_id) == nid_of(m_stage));
    mr = (m_state == 1) && rx_vld_r && (int'(rx_msg_r.src_node_id) == nid_of(m_stage));
    tf = TypeChk ? (rx_msg_f.msg_type == 1'b0) : 1'b1;
    tr = TypeChk ? (rx_msg_r.msg_type == 1'b1) : 1'b1;
    if ((mf && !tf) || (mr && !tr)) m_terr = 1;
    if (hs) begin
      void'(qf.pop_front());
      void'(qr.pop_front());
    end
    if (mf && tf) begin
      if (qf.size() < int'(DEPTH)) qf.push_back(int'(rx_msg_f.fft_pt));
      else m_ovf = 1;
    end
    if (mr && tr) begin
      if (qr.size() < int'(DEPTH)) qr.push_back(int'(rx_msg_r.fft_pt));
      else m_ovf = 1;
    end
    if (m_state == 1) begin
      if (hs) begin
        m_cnt++;
        if (m_cnt == int'(PTS)) begin
          m_cnt = 0;
          m_stage++;
          m_sd = 1;
          if (m_stage == int'(NST)) m_state = 2;
        end
      end
    end else if (start) begin
      m_state = 1; m_stage = 0; m_cnt = 0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (stage_done) sd_seen++;
    chk("out_vld", out_vld, exp_vld());
    chk("out_pt_f", out_pt_f, (qf.size() > 0) ? qf[0] : 0);
    chk("out_pt_r", out_pt_r, (qr.size() > 0) ? qr[0] : 0);
    chk("out_stage", out_stage, m_stage % 4);
    chk("stage_done", stage_done, m_sd);
    chk("done", done, m_state == 2);
    chk("ovf_err", ovf_err, m_ovf);
    chk("type_err", type_err, m_terr);
  endtask

  task automatic idle_in();
    start = 0; rx_vld_f = 0; rx_vld_r = 0;
    rx_msg_f = mk(0, 0, 0); rx_msg_r = mk(0, 1, 0);
  endtask

  initial begin
    rstn = 0; out_rdy = 0;
    idle_in();
    m_state = 0; m_stage = 0; m_cnt = 0; m_sd = 0; m_ovf = 0; m_terr = 0;

    // Reset state
    step(); step();
    rstn = 1;
    step();
    chk("reset_out_vld", out_vld, 0);
    chk("reset_done", done, 0);

    // Start, then a non-partner forward message must be ignored
    start = 1; step(); idle_in();
    rx_vld_f = 1; rx_msg_f = mk(9, 0, 16'h55); step(); idle_in();
    chk("nomatch_out_vld", out_vld, 0);

    // Matching pair arrives in one cycle, visible the next
    rx_vld_f = 1; rx_msg_f = mk(3, 0, 16'h11);
    rx_vld_r = 1; rx_msg_r = mk(3, 1, 16'h22);
    step(); idle_in();
    chk("pair_vld", out_vld, 1);
    chk("pair_f", out_pt_f, 16'h11);
    chk("pair_r", out_pt_r, 16'h22);
    chk("pair_stage", out_stage, 0);
    step();                       // held while out_rdy=0
    chk("hold_f", out_pt_f, 16'h11);
    out_rdy = 1; step(); out_rdy = 0;

    // Overflow: three forward points into a depth-2 FIFO with no pop
    sd_seen = 0;
    for (int i = 0; i < 3; i++) begin
      rx_vld_f = 1; rx_msg_f = mk(3, 0, 16'hA1 + i); step();
    end
    idle_in();
    chk("ovf_flag", ovf_err, 1);
    rx_vld_r = 1; rx_msg_r = mk(3, 1, 16'hB1); step(); idle_in();
    chk("ovf_head1", out_pt_f, 16'hA1);
    out_rdy = 1; rx_vld_r = 1; rx_msg_r = mk(3, 1, 16'hB2); step(); idle_in();
    chk("ovf_head2", out_pt_f, 16'hA2);
    step(); out_rdy = 0;
    chk("ovf_drained", out_vld, 0);

    // Run remaining stages; matching follows NIDS[stage]
    for (int c = 0; c < 60 && m_state == 1; c++) begin
      out_rdy = 1;
      rx_vld_f = 1; rx_msg_f = mk(nid_of(m_stage), 0, $urandom_range(0, 16'hFFFF));
      rx_vld_r = 1; rx_msg_r = mk(nid_of(m_stage), 1, $urandom_range(0, 16'hFFFF));
      step();
    end
    idle_in(); out_rdy = 0;
    chk("all_done", done, 1);
    chk("stage_done_pulses", sd_seen, 3);
    step();

    // Reset with one buffered forward point
    start = 1; step(); idle_in();
    rx_vld_f = 1; rx_msg_f = mk(3, 0, 16'h77); step(); idle_in();
    rstn = 0; step(); rstn = 1;
    chk("rst_vld", out_vld, 0);
    chk("rst_pt_f", out_pt_f, 0);
    chk("rst_ovf", ovf_err, 0);
    rx_vld_r = 1; rx_msg_r = mk(3, 1, 16'h33); step(); idle_in();
    chk("rst_idle_vld", out_vld, 0);

    // Wrong forward msg_type
    start = 1; step(); idle_in();
    rx_vld_f = 1; rx_msg_f = mk(3, 1, 16'h44);
    rx_vld_r = 1; rx_msg_r = mk(3, 1, 16'h45);
    step(); idle_in();
    chk("type_err_flag", type_err, TypeChk);
    chk("type_accept", out_vld, !TypeChk);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rstn     = ($urandom_range(0, 99) != 0);
      start    = ($urandom_range(0, 19) == 0);
      out_rdy  = $urandom_range(0, 1);
      rx_vld_f = $urandom_range(0, 1);
      rx_vld_r = $urandom_range(0, 1);
      rx_msg_f = mk(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : nid_of(m_stage),
                    ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 16'hFFFF));
      rx_msg_r = mk(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : nid_of(m_stage),
                    ($urandom_range(0, 7) == 0) ? 0 : 1, $urandom_range(0, 16'hFFFF));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
